piano_voice_ctrl: RTL and testbench

Single-voice note controller for the piano tone path. It debounces 12 key inputs (C4..B4) and arbitrates between held keys with a last-pressed-wins policy. It drives one programmable square-wave divider whose half-period comes from a fixed note table, optionally shifted up by octaves. It sits between the board key pins and the speaker pin and replaces one fixed divider per note with a single shared divider.

---
 rtl/piano_voice_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_piano_voice_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piano_voice_ctrl.sv
// Single-voice piano note controller: debounces 12 keys, picks the last-pressed
// note and drives one shared square-wave divider with glitch-free note changes.
module piano_voice_ctrl #(
  parameter int DB_TICK    = 500000,
  parameter int DB_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keys,
  input  logic [1:0]  octave,
  output logic        speaker,
  output logic        note_valid,
  output logic [3:0]  note_idx
);

  localparam int TW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SWITCH
  } state_t;

  state_t      state;
  logic [11:0] sync1;
  logic [11:0] sync2;
  logic [11:0] db;
  logic [11:0] db_q;
  logic [3:0]  run_cnt [12];
  logic [TW-1:0] pre_cnt;
  logic        tick;
  logic [11:0] press;
  logic [11:0] release_p;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic [16:0] cnt;
  logic [16:0] cmp_act;
  logic [16:0] cmp_pend;
  logic [3:0]  pend_idx;
  logic [3:0]  base_idx;

  function automatic logic [3:0] lowest(input logic [11:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Half-period minus one for each note, scaled up by whole octaves
  function automatic logic [16:0] note_cmp(input logic [3:0] idx, input logic [1:0] oct);
    logic [16:0] t;
    case (idx)
      4'd0:    t = 17'd95555;
      4'd1:    t = 17'd90193;
      4'd2:    t = 17'd85130;
      4'd3:    t = 17'd80352;
      4'd4:    t = 17'd75842;
      4'd5:    t = 17'd71586;
      4'd6:    t = 17'd67568;
      4'd7:    t = 17'd63775;
      4'd8:    t = 17'd60197;
      4'd9:    t = 17'd56817;
      4'd10:   t = 17'd53629;
      default: t = 17'd50619;
    endcase
    t = t + 17'd1;
    return (t >> oct) - 17'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  assign tick = (pre_cnt == TW'(DB_TICK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // A key flips only after DB_SAMPLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 12; i++) run_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 12; i++) begin
        if (sync2[i] == db[i]) begin
          run_cnt[i] <= '0;
        end else if (run_cnt[i] == 4'(DB_SAMPLES - 1)) begin
          run_cnt[i] <= '0;
          db[i]      <= sync2[i];
        end else begin
          run_cnt[i] <= run_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= '0;
    end else begin
      db_q <= db;
    end
  end

  assign press     = db & ~db_q;
  assign release_p = ~db & db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_valid <= 1'b0;
      sel_idx   <= '0;
    end else if (|press) begin
      sel_valid <= 1'b1;
      sel_idx   <= lowest(press);
    end else if (sel_valid && release_p[sel_idx]) begin
      if (|db) begin
        sel_idx <= lowest(db);
      end else begin
        sel_valid <= 1'b0;
      end
    end
  end

  // The note that will be active after the next toggle
  assign base_idx = (state == SWITCH) ? pend_idx : note_idx;

  // Divider FSM: note changes and stops only happen at toggle boundaries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      speaker    <= 1'b0;
      note_valid <= 1'b0;
      note_idx   <= '0;
      cnt        <= '0;
      cmp_act    <= '0;
      cmp_pend   <= '0;
      pend_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          speaker    <= 1'b0;
          cnt        <= '0;
          note_valid <= 1'b0;
          if (sel_valid) begin
            cmp_act    <= note_cmp(sel_idx, octave);
            note_idx   <= sel_idx;
            note_valid <= 1'b1;
            state      <= PLAY;
          end
        end
        PLAY, SWITCH: begin
          if (!sel_valid && !speaker) begin
            state      <= IDLE;
            note_valid <= 1'b0;
            cnt        <= '0;
          end else if (cnt == cmp_act) begin
            cnt     <= '0;
            speaker <= ~speaker;
            if (!sel_valid) begin
              state      <= IDLE;
              note_valid <= 1'b0;
            end else begin
              if (state == SWITCH) begin
                cmp_act  <= cmp_pend;
                note_idx <= pend_idx;
              end
              if (sel_idx != base_idx) begin
                cmp_pend <= note_cmp(sel_idx, octave);
                pend_idx <= sel_idx;
                state    <= SWITCH;
              end else begin
                state <= PLAY;
              end
            end
          end else begin
            cnt <= cnt + 17'd1;
            if (sel_valid && sel_idx != base_idx) begin
              cmp_pend <= note_cmp(sel_idx, octave);
              pend_idx <= sel_idx;
              state    <= SWITCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piano_voice_ctrl.sv
// Directed bench for piano_voice_ctrl with a fast debounce setup; expected
// half-periods are ((table + 1) >> octave) cycles, worked out by hand.
module tb_piano_voice_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] keys;
  logic [1:0]  octave;
  logic        speaker;
  logic        note_valid;
  logic [3:0]  note_idx;

  int vectors;
  int miscompares;
  int rises;
  bit mon_en;
  int n;

  piano_voice_ctrl #(.DB_TICK(4), .DB_SAMPLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .keys       (keys),
    .octave     (octave),
    .speaker    (speaker),
    .note_valid (note_valid),
    .note_idx   (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge note_valid) begin
    if (mon_en) rises++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] k, input logic [1:0] oct);
    @(negedge clk);
    keys   = k;
    octave = oct;
  endtask

  task automatic wait_valid(input logic lvl, input int bound);
    int c;
    c = 0;
    while (note_valid !== lvl && c < bound) begin
      @(negedge clk);
      c++;
    end
  endtask

  // Cycles until speaker reaches lvl, sampled on falling edges
  task automatic count_speaker(input logic lvl, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (speaker !== lvl && cycles < 40000);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rises       = 0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    keys        = '0;
    octave      = 2'd3;
    repeat (3) @(negedge clk);
    check_output("rst_speaker", 32'(speaker), 32'd0);
    check_output("rst_valid", 32'(note_valid), 32'd0);
    check_output("rst_idx", 32'(note_idx), 32'd0);
    rst = 1'b0;

    $display("[TB] single key G# at octave 3");
    apply_stimulus(12'h100, 2'd3);
    wait_valid(1'b1, 200);
    check_output("gs_valid", 32'(note_valid), 32'd1);
    check_output("gs_idx", 32'(note_idx), 32'd8);
    check_output("gs_start_low", 32'(speaker), 32'd0);
    count_speaker(1'b1, n);
    check_output("gs_first_rise", 32'(n), 32'd7524);
    count_speaker(1'b0, n);
    check_output("gs_half", 32'(n), 32'd7524);
    apply_stimulus(12'h000, 2'd3);
    wait_valid(1'b0, 200);
    check_output("gs_stop_valid", 32'(note_valid), 32'd0);
    repeat (50) @(negedge clk);
    check_output("gs_stop_speaker", 32'(speaker), 32'd0);
    check_output("gs_idx_hold", 32'(note_idx), 32'd8);

    $display("[TB] key A at octave 2, released while high");
    apply_stimulus(12'h200, 2'd2);
    wait_valid(1'b1, 200);
    check_output("a_valid", 32'(note_valid), 32'd1);
    check_output("a_idx", 32'(note_idx), 32'd9);
    count_speaker(1'b1, n);
    check_output("a_first_rise", 32'(n), 32'd14204);
    apply_stimulus(12'h000, 2'd2);
    repeat (60) @(negedge clk);
    check_output("a_no_trunc_valid", 32'(note_valid), 32'd1);
    check_output("a_no_trunc_spk", 32'(speaker), 32'd1);
    count_speaker(1'b0, n);
    check_output("a_last_half", 32'(n + 61), 32'd14204);
    check_output("a_stop_valid", 32'(note_valid), 32'd0);

    $display("[TB] hold C then press E");
    apply_stimulus(12'h001, 2'd3);
    wait_valid(1'b1, 200);
    check_output("c_idx", 32'(note_idx), 32'd0);
    apply_stimulus(12'h011, 2'd3);
    repeat (49) @(negedge clk);
    check_output("ce_idx_before_toggle", 32'(note_idx), 32'd0);
    count_speaker(1'b1, n);
    check_output("ce_c_half_kept", 32'(n + 50), 32'd11944);
    check_output("ce_idx_switched", 32'(note_idx), 32'd4);
    count_speaker(1'b0, n);
    check_output("ce_e_half", 32'(n), 32'd9480);
    apply_stimulus(12'h001, 2'd3);
    repeat (99) @(negedge clk);
    check_output("ce_idx_wait", 32'(note_idx), 32'd4);
    count_speaker(1'b1, n);
    check_output("ce_e_half_end", 32'(n + 100), 32'd9480);
    check_output("ce_idx_back", 32'(note_idx), 32'd0);
    check_output("ce_valid", 32'(note_valid), 32'd1);

    $display("[TB] reset while tone is high");
    rst  = 1'b1;
    keys = '0;
    #1;
    check_output("mid_rst_speaker", 32'(speaker), 32'd0);
    check_output("mid_rst_valid", 32'(note_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_output("post_rst_idle_valid", 32'(note_valid), 32'd0);
    check_output("post_rst_idle_spk", 32'(speaker), 32'd0);

    $display("[TB] simultaneous press of keys 3 and 7");
    apply_stimulus(12'h088, 2'd3);
    wait_valid(1'b1, 200);
    check_output("sim_idx", 32'(note_idx), 32'd3);
    apply_stimulus(12'h008, 2'd3);
    repeat (50) @(negedge clk);
    check_output("sim_rel7_idx", 32'(note_idx), 32'd3);
    check_output("sim_rel7_valid", 32'(note_valid), 32'd1);
    rst  = 1'b1;
    keys = '0;
    #1;
    check_output("rst_idx_clear", 32'(note_idx), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] bouncing key 2");
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      keys[2] = ~keys[2];
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_output("bounce_rejected", 32'(rises), 32'd0);
    keys[2] = 1'b1;
    wait_valid(1'b1, 200);
    repeat (50) @(negedge clk);
    check_output("bounce_one_press", 32'(rises), 32'd1);
    check_output("bounce_idx", 32'(note_idx), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
